// File: rtl/iq_pkg.sv
// Shared types and helpers for the dual-issue instruction queue.
package iq_pkg;

  localparam int unsigned IQ_PAYLOAD_W = 64;

  typedef enum logic {
    NORMAL  = 1'b0,
    WAIT_DS = 1'b1
  } iq_state_t;

  function automatic logic [31:0] iq_pc(input logic [IQ_PAYLOAD_W-1:0] payload);
    return payload[63:32];
  endfunction

  function automatic logic [31:0] iq_inst(input logic [IQ_PAYLOAD_W-1:0] payload);
    return payload[31:0];
  endfunction

endpackage

// File: rtl/iq_mem.sv
// Entry storage: two write ports, combinational reads, data is never reset.
// A third read port supplies the surviving head when a keep-flush relocates it.
module iq_mem
  import iq_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned PAYLOAD_W = IQ_PAYLOAD_W,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we1,
  input  logic [AW-1:0]        waddr1,
  input  logic [PAYLOAD_W-1:0] wdata1,
  input  logic                 we2,
  input  logic [AW-1:0]        waddr2,
  input  logic [PAYLOAD_W-1:0] wdata2,
  input  logic [AW-1:0]        raddr1,
  output logic [PAYLOAD_W-1:0] rdata1,
  input  logic [AW-1:0]        raddr2,
  output logic [PAYLOAD_W-1:0] rdata2,
  input  logic [AW-1:0]        raddr3,
  output logic [PAYLOAD_W-1:0] rdata3
);

  logic [PAYLOAD_W-1:0] mem_q [DEPTH];
  logic [PAYLOAD_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we1) mem_d[waddr1] = wdata1;
    if (we2) mem_d[waddr2] = wdata2;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata1 = mem_q[raddr1];
  assign rdata2 = mem_q[raddr2];
  assign rdata3 = mem_q[raddr3];

endmodule

// File: rtl/inst_queue.sv
// Dual-issue fetch-to-decode instruction queue with branch/exception flush
// and delay-slot retention.
module inst_queue
  import iq_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned PAYLOAD_W = IQ_PAYLOAD_W,
  localparam int unsigned AW       = $clog2(DEPTH),
  localparam int unsigned CW       = AW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 flush_keep_head,
  input  logic                 write_en1,
  input  logic                 write_en2,
  input  logic [PAYLOAD_W-1:0] write_data1,
  input  logic [PAYLOAD_W-1:0] write_data2,
  input  logic                 read_en1,
  input  logic                 read_en2,
  output logic [PAYLOAD_W-1:0] read_data1,
  output logic [PAYLOAD_W-1:0] read_data2,
  output logic                 read_valid1,
  output logic                 read_valid2,
  output logic                 empty,
  output logic                 almost_empty,
  output logic                 full,
  output logic [CW-1:0]        count
);

  iq_state_t            state_q, state_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [CW-1:0]        pop_req, pop_n, push_n, remain;
  logic                 mem_we1, mem_we2;
  logic [AW-1:0]        mem_wa1;
  logic [PAYLOAD_W-1:0] mem_wd1;
  logic [PAYLOAD_W-1:0] mem_rd1, mem_rd2, mem_rd3;

  iq_mem #(.DEPTH(DEPTH), .PAYLOAD_W(PAYLOAD_W)) u_mem (
    .clk    (clk),
    .we1    (mem_we1),
    .waddr1 (mem_wa1),
    .wdata1 (mem_wd1),
    .we2    (mem_we2),
    .waddr2 (wr_ptr_q + AW'(1)),
    .wdata2 (write_data2),
    .raddr1 (rd_ptr_q),
    .rdata1 (mem_rd1),
    .raddr2 (rd_ptr_q + AW'(1)),
    .rdata2 (mem_rd2),
    .raddr3 (rd_ptr_q + AW'(2)),
    .rdata3 (mem_rd3)
  );

  // Next-state: pops first, then flush (which overrides pushes) or pushes.
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    mem_we1  = 1'b0;
    mem_we2  = 1'b0;
    mem_wa1  = wr_ptr_q;
    mem_wd1  = write_data1;

    pop_req = CW'(read_en1) + CW'(read_en1 & read_en2);
    pop_n   = (pop_req > count_q) ? count_q : pop_req;
    remain  = count_q - pop_n;

    push_n = '0;
    if (!full && write_en1) begin
      push_n = (state_q == WAIT_DS) ? CW'(1) : CW'(1) + CW'(write_en2);
    end

    if (flush) begin
      if (flush_keep_head && (remain != '0)) begin
        // Surviving head is relocated into the slot at rd_ptr.
        wr_ptr_d = rd_ptr_q + AW'(1);
        count_d  = CW'(1);
        state_d  = NORMAL;
        if (pop_n != '0) begin
          mem_we1 = 1'b1;
          mem_wa1 = rd_ptr_q;
          mem_wd1 = (pop_n == CW'(1)) ? mem_rd2 : mem_rd3;
        end
      end else begin
        rd_ptr_d = '0;
        wr_ptr_d = '0;
        count_d  = '0;
        state_d  = flush_keep_head ? WAIT_DS : NORMAL;
      end
    end else begin
      rd_ptr_d = rd_ptr_q + AW'(pop_n);
      wr_ptr_d = wr_ptr_q + AW'(push_n);
      count_d  = count_q - pop_n + push_n;
      mem_we1  = (push_n != '0);
      mem_we2  = (push_n == CW'(2));
      if ((state_q == WAIT_DS) && (push_n != '0)) state_d = NORMAL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= NORMAL;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign read_valid1  = (count_q != '0);
  assign read_valid2  = (count_q >= CW'(2));
  assign empty        = (count_q == '0);
  assign almost_empty = (count_q == CW'(1));
  assign full         = (count_q >= CW'(DEPTH - 1));
  assign count        = count_q;
  assign read_data1   = read_valid1 ? mem_rd1 : '0;
  assign read_data2   = read_valid2 ? mem_rd2 : '0;

endmodule

// File: tb/tb_inst_queue.sv
// Testbench for inst_queue: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_inst_queue;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned PW    = 64;
  localparam int unsigned CW    = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush, flush_keep_head;
  logic          write_en1, write_en2;
  logic [PW-1:0] write_data1, write_data2;
  logic          read_en1, read_en2;
  logic [PW-1:0] read_data1, read_data2;
  logic          read_valid1, read_valid2;
  logic          empty, almost_empty, full;
  logic [CW-1:0] count;

  int errors = 0;
  int checks = 0;

  logic [PW-1:0] mq[$];
  bit            m_wait;

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PW)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .flush_keep_head (flush_keep_head),
    .write_en1       (write_en1),
    .write_en2       (write_en2),
    .write_data1     (write_data1),
    .write_data2     (write_data2),
    .read_en1        (read_en1),
    .read_en2        (read_en2),
    .read_data1      (read_data1),
    .read_data2      (read_data2),
    .read_valid1     (read_valid1),
    .read_valid2     (read_valid2),
    .empty           (empty),
    .almost_empty    (almost_empty),
    .full            (full),
    .count           (count)
  );

  function automatic logic [PW-1:0] exp_d(input int i);
    return (mq.size() > i) ? mq[i] : '0;
  endfunction

  function automatic logic [4:0] exp_flags();
    int n;
    n = mq.size();
    return {n == 0, n == 1, n >= DEPTH - 1, n >= 1, n >= 2};
  endfunction

  task automatic idle_inputs();
    flush = 0; flush_keep_head = 0;
    write_en1 = 0; write_en2 = 0; write_data1 = '0; write_data2 = '0;
    read_en1 = 0; read_en2 = 0;
  endtask

  // Drive one cycle of stimulus and advance the reference model.
  task automatic step(input bit we1, input bit we2, input logic [PW-1:0] d1,
                      input logic [PW-1:0] d2, input bit re1, input bit re2,
                      input bit fl, input bit kp);
    int n;
    bit was_full;
    logic [PW-1:0] h;
    write_en1 = we1; write_en2 = we2; write_data1 = d1; write_data2 = d2;
    read_en1 = re1; read_en2 = re2; flush = fl; flush_keep_head = kp;
    @(posedge clk);
    was_full = (mq.size() >= DEPTH - 1);
    n = re1 ? (re2 ? 2 : 1) : 0;
    if (n > mq.size()) n = mq.size();
    for (int k = 0; k < n; k++) void'(mq.pop_front());
    if (fl) begin
      if (kp && mq.size() > 0) begin
        h = mq[0];
        mq.delete();
        mq.push_back(h);
        m_wait = 0;
      end else begin
        mq.delete();
        m_wait = kp;
      end
    end else if (we1 && !was_full) begin
      mq.push_back(d1);
      if (m_wait) m_wait = 0;
      else if (we2) mq.push_back(d2);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_wait = 0;
    @(negedge clk);
    checks++;
    if (count !== 5'd0) begin
      errors++; $display("FAIL reset_count got=%0d exp=0", count);
    end
    checks++;
    if ({empty, almost_empty, full, read_valid1, read_valid2} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=10000", {empty, almost_empty, full, read_valid1, read_valid2});
    end
    checks++;
    if (read_data1 !== '0 || read_data2 !== '0) begin
      errors++; $display("FAIL reset_data got=%h/%h exp=0/0", read_data1, read_data2);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 64'hA0 + 64'(2 * i), 64'hA1 + 64'(2 * i), 0, 0, 0, 0);
      checks++;
      if (count !== 5'(mq.size())) begin
        errors++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count, mq.size());
      end
      checks++;
      if (full !== (mq.size() >= DEPTH - 1)) begin
        errors++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, full, mq.size() >= DEPTH - 1);
      end
    end
    checks++;
    if (count !== 5'd16 || full !== 1'b1) begin
      errors++; $display("FAIL fill_final got count=%0d full=%b exp count=16 full=1", count, full);
    end
    checks++;
    if (read_data1 !== 64'hA0 || read_data2 !== 64'hA1) begin
      errors++; $display("FAIL fill_head got=%h/%h exp=a0/a1", read_data1, read_data2);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (read_data1 !== exp_d(0) || read_data2 !== exp_d(1)) begin
        errors++;
        $display("FAIL drain_data i=%0d got=%h/%h exp=%h/%h", i, read_data1, read_data2, exp_d(0), exp_d(1));
      end
      step(0, 0, '0, '0, 1, 1, 0, 0);
    end
  endtask

  task automatic test_underflow();
    step(1, 0, 64'h55, '0, 0, 0, 0, 0);
    checks++;
    if (count !== 5'd1 || almost_empty !== 1'b1) begin
      errors++; $display("FAIL uflow_setup got count=%0d ae=%b exp 1/1", count, almost_empty);
    end
    step(0, 0, '0, '0, 1, 1, 0, 0);
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || read_valid2 !== 1'b0 || read_data2 !== '0) begin
      errors++;
      $display("FAIL uflow got count=%0d empty=%b rv2=%b rd2=%h exp 0/1/0/0", count, empty, read_valid2, read_data2);
    end
  endtask

  task automatic test_wrap();
    test_reset();
    for (int i = 0; i < 15; i++) begin
      step(1, 0, 64'h100 + 64'(i), '0, 0, 0, 0, 0);
      step(0, 0, '0, '0, 1, 0, 0, 0);
    end
    step(1, 1, 64'hDEAD_0001_0000_0050, 64'hDEAD_0002_0000_0051, 0, 0, 0, 0);
    checks++;
    if (read_data1 !== 64'hDEAD_0001_0000_0050 || read_data2 !== 64'hDEAD_0002_0000_0051 || count !== 5'd2) begin
      errors++; $display("FAIL wrap_pq got=%h/%h cnt=%0d exp P/Q cnt=2", read_data1, read_data2, count);
    end
    step(0, 0, '0, '0, 1, 1, 0, 0);
    checks++;
    if (empty !== 1'b1) begin
      errors++; $display("FAIL wrap_pop got empty=%b exp=1", empty);
    end
    step(1, 1, 64'h77, 64'h78, 0, 0, 0, 0);
    checks++;
    if (read_data1 !== 64'h77 || read_data2 !== 64'h78) begin
      errors++; $display("FAIL wrap_after got=%h/%h exp=77/78", read_data1, read_data2);
    end
    step(0, 0, '0, '0, 1, 1, 0, 0);
  endtask

  task automatic test_keep_flush_entries();
    step(1, 1, 64'hE0, 64'hE1, 0, 0, 0, 0);
    step(1, 1, 64'hE2, 64'hE3, 0, 0, 0, 0);
    step(1, 0, 64'hE4, '0, 0, 0, 0, 0);
    checks++;
    if (count !== 5'd5) begin
      errors++; $display("FAIL kf_setup got=%0d exp=5", count);
    end
    // Pushes in the flush cycle must be dropped.
    step(1, 1, 64'hBAD0, 64'hBAD1, 1, 0, 1, 1);
    checks++;
    if (count !== 5'd1 || read_data1 !== 64'hE1 || read_valid2 !== 1'b0 || read_data2 !== '0) begin
      errors++;
      $display("FAIL kf_entries got cnt=%0d rd1=%h rv2=%b rd2=%h exp 1/e1/0/0", count, read_data1, read_valid2, read_data2);
    end
    step(0, 0, '0, '0, 1, 0, 0, 0);
  endtask

  task automatic test_keep_flush_empty();
    step(1, 0, 64'hD0, '0, 0, 0, 0, 0);
    step(0, 0, '0, '0, 1, 0, 1, 1);
    checks++;
    if (count !== 5'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL kfe_flush got cnt=%0d empty=%b exp 0/1", count, empty);
    end
    step(1, 1, 64'hD5, 64'hFF, 1, 1, 0, 0);
    checks++;
    if (count !== 5'd1 || read_data1 !== 64'hD5 || read_data2 !== '0) begin
      errors++; $display("FAIL kfe_ds got cnt=%0d rd1=%h rd2=%h exp 1/d5/0", count, read_data1, read_data2);
    end
    step(1, 1, 64'hC1, 64'hC2, 0, 0, 0, 0);
    checks++;
    if (count !== 5'd3 || read_data2 !== 64'hC1) begin
      errors++; $display("FAIL kfe_next got cnt=%0d rd2=%h exp 3/c1", count, read_data2);
    end
    step(0, 0, '0, '0, 0, 0, 1, 0);
    checks++;
    if (count !== 5'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL plain_flush got cnt=%0d empty=%b exp 0/1", count, empty);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) step(1, 1, 64'h300 + 64'(2 * i), 64'h301 + 64'(2 * i), 0, 0, 0, 0);
    step(1, 0, 64'h306, '0, 0, 0, 0, 0);
    checks++;
    if (count !== 5'd7) begin
      errors++; $display("FAIL ares_setup got=%0d exp=7", count);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      errors++; $display("FAIL ares_async got empty=%b cnt=%0d exp 1/0", empty, count);
    end
    mq.delete();
    m_wait = 0;
    #1 rst = 1'b0;
    @(negedge clk);
    step(1, 0, 64'h400, '0, 0, 0, 0, 0);
    checks++;
    if (count !== 5'd1 || read_data1 !== 64'h400) begin
      errors++; $display("FAIL ares_recover got cnt=%0d rd1=%h exp 1/400", count, read_data1);
    end
  endtask

  task automatic test_random();
    bit we1, we2, re1, re2, fl, kp;
    int wp, rp;
    for (int i = 0; i < 600; i++) begin
      wp = ((i % 100) < 50) ? 85 : 30;
      rp = ((i % 100) < 50) ? 30 : 80;
      we1 = ($urandom_range(0, 99) < wp);
      we2 = ($urandom_range(0, 99) < 70);
      re1 = ($urandom_range(0, 99) < rp);
      re2 = ($urandom_range(0, 99) < 60);
      fl  = ($urandom_range(0, 99) < 4);
      kp  = ($urandom_range(0, 1) == 1);
      step(we1, we2, {$urandom, $urandom}, {$urandom, $urandom}, re1, re2, fl, kp);
      checks++;
      if (count !== 5'(mq.size())) begin
        errors++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, count, mq.size());
      end
      checks++;
      if ({empty, almost_empty, full, read_valid1, read_valid2} !== exp_flags()) begin
        errors++;
        $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", i, {empty, almost_empty, full, read_valid1, read_valid2}, exp_flags());
      end
      checks++;
      if (read_data1 !== exp_d(0)) begin
        errors++; $display("FAIL rnd_rd1 cyc=%0d got=%h exp=%h", i, read_data1, exp_d(0));
      end
      checks++;
      if (read_data2 !== exp_d(1)) begin
        errors++; $display("FAIL rnd_rd2 cyc=%0d got=%h exp=%h", i, read_data2, exp_d(1));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_fill();
    test_underflow();
    test_wrap();
    test_keep_flush_entries();
    test_keep_flush_empty();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
